// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants at most one output
// buffer per cycle and tracks per-requester wait time for starvation detection.
module cdb_arbiter #(
  parameter int N_REQUESTERS = 4,
  parameter int IDX_WIDTH    = (N_REQUESTERS > 1) ? $clog2(N_REQUESTERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQUESTERS-1:0] request,
  output logic [N_REQUESTERS-1:0] permit,
  output logic                    cdb_valid,
  output logic [IDX_WIDTH-1:0]    grant_index,
  output logic                    starvation_error
);

  localparam logic [IDX_WIDTH:0]   WAIT_MAX = (IDX_WIDTH+1)'(N_REQUESTERS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_REQUESTERS - 1);

  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH:0]   wait_cnt [N_REQUESTERS];
  logic                 found;
  logic [IDX_WIDTH-1:0] gidx;
  logic [N_REQUESTERS-1:0] onehot;
  logic                 any_sat;

  // Wait counter step: count up while blocked, saturating at N_REQUESTERS.
  function automatic logic [IDX_WIDTH:0] sat_inc(input logic [IDX_WIDTH:0] cnt);
    if (cnt >= WAIT_MAX)
      return WAIT_MAX;
    return cnt + (IDX_WIDTH+1)'(1);
  endfunction

  // Cyclic scan from ptr: first look at indices >= ptr, then wrap to the low ones.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < N_REQUESTERS; i++) begin
      if (!found && request[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        gidx  = IDX_WIDTH'(i);
      end
    end
    for (int i = 0; i < N_REQUESTERS; i++) begin
      if (!found && request[i]) begin
        found = 1'b1;
        gidx  = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_REQUESTERS; i++)
      onehot[i] = found && (gidx == IDX_WIDTH'(i));
  end

  // Reset is gated into the outputs so no buffer can pop during a reset cycle.
  always_comb begin
    permit      = reset ? '0 : onehot;
    cdb_valid   = |permit;
    grant_index = (reset || !found) ? '0 : gidx;
  end

  always_comb begin
    any_sat = 1'b0;
    for (int i = 0; i < N_REQUESTERS; i++)
      if (wait_cnt[i] == WAIT_MAX)
        any_sat = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr              <= '0;
      starvation_error <= 1'b0;
      for (int i = 0; i < N_REQUESTERS; i++)
        wait_cnt[i] <= '0;
    end else begin
      if (found)
        ptr <= (gidx == LAST_IDX) ? '0 : gidx + IDX_WIDTH'(1);
      if (any_sat)
        starvation_error <= 1'b1;
      for (int i = 0; i < N_REQUESTERS; i++) begin
        if (request[i] && !permit[i])
          wait_cnt[i] <= sat_inc(wait_cnt[i]);
        else
          wait_cnt[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for N=4 plus hand sequences
// for a non-power-of-2 instance (N=3) and the degenerate N=1 instance.
module tb_cdb_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req4;
  logic [2:0] req3;
  logic [0:0] req1;

  logic [3:0] permit4;
  logic       valid4;
  logic [1:0] idx4;
  logic       starv4;
  logic [2:0] permit3;
  logic       valid3;
  logic [1:0] idx3;
  logic       starv3;
  logic [0:0] permit1;
  logic       valid1;
  logic [0:0] idx1;
  logic       starv1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQUESTERS(4)) dut4 (
    .clk(clk), .reset(reset), .request(req4), .permit(permit4),
    .cdb_valid(valid4), .grant_index(idx4), .starvation_error(starv4)
  );

  cdb_arbiter #(.N_REQUESTERS(3)) dut3 (
    .clk(clk), .reset(reset), .request(req3), .permit(permit3),
    .cdb_valid(valid3), .grant_index(idx3), .starvation_error(starv3)
  );

  cdb_arbiter #(.N_REQUESTERS(1)) dut1 (
    .clk(clk), .reset(reset), .request(req1), .permit(permit1),
    .cdb_valid(valid1), .grant_index(idx1), .starvation_error(starv1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] exp_permit;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] p,
                     input logic [1:0] i);
    vec_t v;
    v.rst = r; v.req = q; v.exp_permit = p; v.exp_idx = i;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    req4  = '0;
    req3  = '0;
    req1  = '0;

    // Reset with all requesting, then eight cycles of full rotation
    add(1, 4'b1111, 4'b0000, 0);
    add(1, 4'b1111, 4'b0000, 0);
    add(0, 4'b1111, 4'b0001, 0);
    add(0, 4'b1111, 4'b0010, 1);
    add(0, 4'b1111, 4'b0100, 2);
    add(0, 4'b1111, 4'b1000, 3);
    add(0, 4'b1111, 4'b0001, 0);
    add(0, 4'b1111, 4'b0010, 1);
    add(0, 4'b1111, 4'b0100, 2);
    add(0, 4'b1111, 4'b1000, 3);
    // Single requester held: repeated grants, ptr left at 3
    add(0, 4'b0100, 4'b0100, 2);
    add(0, 4'b0100, 4'b0100, 2);
    add(0, 4'b0100, 4'b0100, 2);
    // Skip and wrap from ptr=3
    add(0, 4'b0011, 4'b0001, 0);
    add(0, 4'b0011, 4'b0010, 1);
    add(0, 4'b0011, 4'b0001, 0);
    add(0, 4'b1000, 4'b1000, 3);
    add(0, 4'b1111, 4'b0001, 0);
    // Idle cycle holds ptr=1
    add(0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 4'b0010, 1);
    // Dropped request at ptr=2: requester 3 withdraws before its turn
    add(0, 4'b1100, 4'b0100, 2);
    add(0, 4'b0011, 4'b0001, 0);
    add(0, 4'b1111, 4'b0010, 1);
    // Reset in the cycle that would grant 2, then restart from 0
    add(1, 4'b1111, 4'b0000, 0);
    add(0, 4'b1111, 4'b0001, 0);
    add(0, 4'b1111, 4'b0010, 1);

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      reset = vecs[r].rst;
      req4  = vecs[r].req;
      req1  = vecs[r].req[0];
      @(negedge clk);
      chk("permit4", r, 32'(permit4), 32'(vecs[r].exp_permit));
      chk("valid4", r, 32'(valid4), 32'(|vecs[r].exp_permit));
      chk("idx4", r, 32'(idx4), 32'(vecs[r].exp_idx));
      chk("permit1", r, 32'(permit1), 32'(vecs[r].rst ? 1'b0 : vecs[r].req[0]));
      chk("idx1", r, 32'(idx1), 32'd0);
      if (r >= 2) begin
        chk("starv4", r, 32'(starv4), 32'd0);
        chk("starv1", r, 32'(starv1), 32'd0);
      end
    end

    // N=3: reset, then all three requesting for six cycles
    @(posedge clk);
    #1;
    reset = 1'b1;
    req4  = '0;
    req1  = '0;
    req3  = 3'b111;
    @(negedge clk);
    chk("permit3_rst", 0, 32'(permit3), 32'd0);
    chk("idx3_rst", 0, 32'(idx3), 32'd0);
    begin
      logic [1:0] exp3 [6];
      exp3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idx3", c, 32'(idx3), 32'(exp3[c]));
        chk("permit3", c, 32'(permit3), 32'(3'b001 << exp3[c]));
        chk("valid3", c, 32'(valid3), 32'd1);
        chk("starv3", c, 32'(starv3), 32'd0);
        chk("idle4", c, 32'(permit4), 32'd0);
      end
    end

    // N=1 follows request straight through
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      req3 = '0;
      req1 = 1'(c % 2);
      @(negedge clk);
      chk("permit1_seq", c, 32'(permit1), 32'(c % 2));
      chk("valid1_seq", c, 32'(valid1), 32'(c % 2));
      chk("idx1_seq", c, 32'(idx1), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
